ship_control_sequencer: RTL

Frame-synchronous controller that sequences the player ship datapath. Turns raw left/right/fire buttons into one-cycle `left`/`right` step pulses for the ship position logic and a `fire` launch pulse, with the launch X taken from the ship's current `gunPosition`. Sits between the board button inputs, the VGA position counters, the ship block and the laser block. Every action is scheduled once per video frame, so ship speed is independent of `clk` rate.

---
 rtl/ship_control_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ship_control_sequencer.sv
`timescale 1ns/1ps
// ship_control_sequencer
// Frame-synchronous sequencer for the player ship. It synchronises the raw
// buttons, derives one tick per video frame from vPos, and issues one-cycle
// left/right step pulses and fire launch pulses on frame ticks.
// Optional feature macro: SHIP_AUTOREPEAT_EN (held-direction auto-repeat).
// Without the macro a held direction steps once per press.
// Handshake: left/right/fire are single-cycle strobes with no back-pressure;
// the consumer must act in the cycle a strobe is high. laserX is a level that
// changes only on the edge that raises fire.
module ship_control_sequencer #(
    parameter int SCREEN_HEIGHT = 480,
    parameter int SCREEN_WIDTH  = 640,
    parameter int REPEAT_DELAY  = 15,
    parameter int REPEAT_PERIOD = 4,
    parameter int FIRE_COOLDOWN = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnFire,
    input  logic [9:0] vPos,
    input  logic [9:0] gunPosition,
    input  logic       laserActive,
    output logic       left,
    output logic       right,
    output logic       fire,
    output logic [9:0] laserX,
    output logic [1:0] move_state_dbg
);

    localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W      = (REPEAT_MAX > 1) ? $clog2(REPEAT_MAX) : 1;
    localparam int COOL_W     = $clog2(FIRE_COOLDOWN + 1);

`ifdef SHIP_AUTOREPEAT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DELAY = 2'd1, S_REPEAT = 2'd2} move_state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1} move_state_t;
`endif

    // Bit order of the button vectors: [0]=left, [1]=right, [2]=fire.
    logic [2:0]        btn_meta_q, btn_meta_d;
    logic [2:0]        btn_sync_q, btn_sync_d;
    logic              end_zone_q, end_zone_d;
    logic              frame_tick_q, frame_tick_d;
    move_state_t       state_q, state_d;
    logic              dir_q, dir_d;        // 1 = right, 0 = left
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [COOL_W-1:0] cool_q, cool_d;
    logic              left_q, left_d;
    logic              right_q, right_d;
    logic              fire_q, fire_d;
    logic [9:0]        laser_x_q, laser_x_d;

    logic s_l, s_r, s_f, dir_valid, cur_dir;

    assign s_l       = btn_sync_q[0];
    assign s_r       = btn_sync_q[1];
    assign s_f       = btn_sync_q[2];
    // Both buttons held is treated as no direction at all.
    assign dir_valid = s_l ^ s_r;
    assign cur_dir   = s_r;

    // Two-stage synchroniser and frame-tick edge detector.
    always_comb begin
        btn_meta_d   = {btnFire, btnRight, btnLeft};
        btn_sync_d   = btn_meta_q;
        end_zone_d   = (vPos == 10'(SCREEN_HEIGHT));
        frame_tick_d = end_zone_d & ~end_zone_q;
    end

    // Move FSM: next state and step pulses, evaluated only on frame ticks.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        if (frame_tick_q) begin
            case (state_q)
                S_IDLE: begin
                    if (dir_valid) begin
                        left_d  = ~cur_dir;
                        right_d = cur_dir;
                        dir_d   = cur_dir;
`ifdef SHIP_AUTOREPEAT_EN
                        cnt_d   = CNT_W'(REPEAT_DELAY - 1);
                        state_d = S_DELAY;
`else
                        state_d = S_HOLD;
`endif
                    end
                end
`ifdef SHIP_AUTOREPEAT_EN
                S_DELAY, S_REPEAT: begin
                    // A reversal drops to IDLE first; it is stepped next tick.
                    if (!dir_valid || (cur_dir != dir_q)) begin
                        state_d = S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        left_d  = ~dir_q;
                        right_d = dir_q;
                        cnt_d   = CNT_W'(REPEAT_PERIOD - 1);
                        state_d = S_REPEAT;
                    end
                end
`else
                S_HOLD: begin
                    if (!dir_valid || (cur_dir != dir_q)) begin
                        state_d = S_IDLE;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Fire cooldown and launch-position capture, evaluated on frame ticks.
    always_comb begin
        cool_d    = cool_q;
        fire_d    = 1'b0;
        laser_x_d = laser_x_q;
        if (frame_tick_q) begin
            if (cool_q != '0) begin
                cool_d = cool_q - COOL_W'(1);
            end else if (s_f && !laserActive) begin
                fire_d    = 1'b1;
                laser_x_d = gunPosition;
                cool_d    = COOL_W'(FIRE_COOLDOWN);
            end
        end
    end

    // Synchroniser and frame-tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            end_zone_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            btn_meta_q   <= btn_meta_d;
            btn_sync_q   <= btn_sync_d;
            end_zone_q   <= end_zone_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Move FSM state, direction latch, repeat counter and step outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // Fire cooldown counter, fire strobe and captured launch X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cool_q    <= '0;
            fire_q    <= 1'b0;
            laser_x_q <= 10'(SCREEN_WIDTH / 2);
        end else begin
            cool_q    <= cool_d;
            fire_q    <= fire_d;
            laser_x_q <= laser_x_d;
        end
    end

    assign left           = left_q;
    assign right          = right_q;
    assign fire           = fire_q;
    assign laserX         = laser_x_q;
    assign move_state_dbg = state_q;

endmodule
